// File: rtl/rom_fetch_ctrl.sv
// Instruction-fetch front end for a synchronous ROM: prefetches sequential words
// into a small queue and redirects the prefetch stream when the core jumps away.
module rom_fetch_ctrl #(
  parameter int unsigned    MDW      = 32,
  parameter int unsigned    MAW      = 32,
  parameter int unsigned    DEPTH    = 2,
  parameter logic [MAW-1:0] RST_ADDR = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic           romcs_n,
  output logic [MAW-1:0] romaddr,
  input  logic [MDW-1:0] romdout,
  input  logic           fetch_req,
  input  logic [MAW-1:0] fetch_addr,
  output logic           fetch_ack,
  output logic [MDW-1:0] fetch_data
);

  localparam int unsigned WAW = MAW - 2;
  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = $clog2(DEPTH + 1);

  logic [WAW-1:0] r_pfAddr;
  logic [WAW-1:0] r_qAddr [DEPTH];
  logic [MDW-1:0] r_qData [DEPTH];
  logic [PW-1:0]  r_head;
  logic [PW-1:0]  r_tail;
  logic [CW-1:0]  r_count;
  logic           r_inflight;
  logic [WAW-1:0] r_inflightAddr;
  logic           r_discard;
  logic           r_redirect;

  logic [WAW-1:0] w_reqWord;
  logic [WAW-1:0] w_expected;
  logic [CW:0]    w_occ;
  logic           w_qEmpty;
  logic           w_retValid;
  logic           w_qHit;
  logic           w_bypass;
  logic           w_redirect;
  logic           w_issue;
  logic           w_push;
  logic           w_pop;
  logic           w_unusedLowBits;

  function automatic logic [PW-1:0] ptrNext(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_reqWord       = fetch_addr[MAW-1:2];
  assign w_unusedLowBits = ^fetch_addr[1:0];
  assign w_qEmpty        = (r_count == '0);
  assign w_retValid      = r_inflight & ~r_discard;

  assign w_qHit   = fetch_req & ~w_qEmpty & (r_qAddr[r_head] == w_reqWord);
  assign w_bypass = fetch_req & w_qEmpty & w_retValid & (r_inflightAddr == w_reqWord);

  // The word the stream will deliver next; a request for it just waits instead of
  // restarting the stream, which keeps a redirect from re-triggering itself.
  always_comb begin
    w_expected = r_pfAddr;
    if (!w_qEmpty) begin
      w_expected = r_qAddr[r_head];
    end else if (w_retValid) begin
      w_expected = r_inflightAddr;
    end
  end

  assign w_redirect = fetch_req & (w_reqWord != w_expected);

  assign w_occ   = (CW+1)'(r_count) + (CW+1)'(r_inflight);
  assign w_issue = rst_n & ~r_redirect & (w_occ < (CW+1)'(DEPTH));
  assign w_push  = w_retValid & ~w_bypass & ~w_redirect;
  assign w_pop   = w_qHit;

  assign romcs_n    = ~w_issue;
  assign romaddr    = w_issue ? {r_pfAddr, 2'b00} : '0;
  assign fetch_ack  = w_qHit | w_bypass;
  assign fetch_data = w_qHit ? r_qData[r_head] : (w_bypass ? romdout : '0);

  // Prefetch pointer and the single outstanding ROM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pfAddr       <= RST_ADDR[MAW-1:2];
      r_inflight     <= 1'b0;
      r_inflightAddr <= '0;
      r_discard      <= 1'b0;
      r_redirect     <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_discard  <= w_issue & w_redirect;
      r_redirect <= w_redirect;
      if (w_issue) begin
        r_inflightAddr <= r_pfAddr;
      end
      if (w_redirect) begin
        r_pfAddr <= w_reqWord;
      end else if (w_issue) begin
        r_pfAddr <= r_pfAddr + WAW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_redirect) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= ptrNext(r_tail);
      end
      if (w_pop) begin
        r_head <= ptrNext(r_head);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue payload needs no reset; the count alone says which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_qAddr[r_tail] <= r_inflightAddr;
      r_qData[r_tail] <= romdout;
    end
  end

  noOverflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && !w_pop && (r_count == CW'(DEPTH))));

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Randomized and directed bench for rom_fetch_ctrl against a queue-based reference
// model; the ROM returns 0x1000_0000 + word index for every read.
module tb_rom_fetch_ctrl;

  localparam int MDW   = 32;
  localparam int MAW   = 12;
  localparam int DEPTH = 2;
  localparam logic [MAW-1:0] RST_ADDR = '0;
  localparam int WORDS = 1 << (MAW - 2);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           romcs_n;
  logic [MAW-1:0] romaddr;
  logic [MDW-1:0] romdout = '0;
  logic           fetch_req = 1'b0;
  logic [MAW-1:0] fetch_addr = '0;
  logic           fetch_ack;
  logic [MDW-1:0] fetch_data;

  int vectorCount = 0;
  int missCount = 0;

  int mq[$];
  bit mInflight;
  bit mDiscard;
  bit mRedirPrev;
  int mInfAddr;
  int mPf;

  rom_fetch_ctrl #(.MDW(MDW), .MAW(MAW), .DEPTH(DEPTH), .RST_ADDR(RST_ADDR)) dut (
    .clk(clk), .rst_n(rst_n), .romcs_n(romcs_n), .romaddr(romaddr), .romdout(romdout),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
    .fetch_data(fetch_data)
  );

  always #5 clk = ~clk;

  // ROM: word returned the cycle after chip select, junk otherwise.
  always @(posedge clk)
    romdout <= (!romcs_n) ? (32'h1000_0000 + 32'(romaddr[MAW-1:2])) : $urandom;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectorCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mInflight  = 1'b0;
    mDiscard   = 1'b0;
    mRedirPrev = 1'b0;
    mInfAddr   = 0;
    mPf        = int'(RST_ADDR[MAW-1:2]);
  endtask

  // One cycle: drive inputs, check outputs against the model, advance the model.
  task automatic applyStimulus(input logic req, input logic [MAW-1:0] addr, output logic ackSeen);
    int reqWord, expWord;
    bit expCs, hitQ, byp, redir, expAck;
    @(negedge clk);
    fetch_req  = req;
    fetch_addr = addr;
    #1;
    ackSeen = fetch_ack;
    if (!rst_n) begin
      checkOutput("rstCs", 64'(romcs_n), 64'd1);
      checkOutput("rstAddr", 64'(romaddr), 64'd0);
      checkOutput("rstAck", 64'(fetch_ack), 64'd0);
      checkOutput("rstData", 64'(fetch_data), 64'd0);
      modelReset();
      return;
    end
    reqWord = int'(addr[MAW-1:2]);
    expCs = !(((mq.size() + int'(mInflight)) < DEPTH) && !mRedirPrev);
    if (mq.size() != 0) expWord = mq[0];
    else if (mInflight && !mDiscard) expWord = mInfAddr;
    else expWord = mPf;
    hitQ   = req && (mq.size() != 0) && (mq[0] == reqWord);
    byp    = req && (mq.size() == 0) && mInflight && !mDiscard && (mInfAddr == reqWord);
    redir  = req && (reqWord != expWord);
    expAck = hitQ || byp;
    checkOutput("romcs_n", 64'(romcs_n), 64'(expCs));
    checkOutput("romaddr", 64'(romaddr), expCs ? 64'd0 : 64'(mPf * 4));
    checkOutput("ack", 64'(fetch_ack), 64'(expAck));
    checkOutput("data", 64'(fetch_data), expAck ? 64'(32'h1000_0000 + reqWord) : 64'd0);
    if (redir) begin
      mq.delete();
    end else begin
      if (hitQ) void'(mq.pop_front());
      if (mInflight && !mDiscard && !byp) mq.push_back(mInfAddr);
    end
    mDiscard   = !expCs && redir;
    mInflight  = !expCs;
    mInfAddr   = mPf;
    mPf        = redir ? reqWord : (!expCs ? (mPf + 1) % WORDS : mPf);
    mRedirPrev = redir;
  endtask

  task automatic holdReq(input logic [MAW-1:0] addr, input int maxC, output int cyc,
                         output logic [MDW-1:0] data);
    logic a;
    cyc  = 0;
    data = '0;
    do begin
      applyStimulus(1'b1, addr, a);
      cyc++;
    end while (!a && cyc < maxC);
    if (a) data = fetch_data;
    else checkOutput("ackTimeout", 64'd0, 64'd1);
  endtask

  task automatic pulseReset(input int cycles);
    logic a;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncCs", 64'(romcs_n), 64'd1);
    checkOutput("asyncAck", 64'(fetch_ack), 64'd0);
    modelReset();
    for (int i = 0; i < cycles; i++) applyStimulus(1'b1, 12'h000, a);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic a;
    logic active;
    int cyc, issues, r;
    logic [MDW-1:0] d;
    logic [MAW-1:0] cur, last;

    modelReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 12'h000, a);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    issues = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 12'h000, a);
      if (!romcs_n) issues++;
    end
    checkOutput("idleIssues", 64'(issues), 64'd2);

    for (int i = 0; i < 4; i++) begin
      holdReq(12'(i * 4), 6, cyc, d);
      checkOutput("seqLatency", 64'(cyc), 64'd1);
      checkOutput("seqData", 64'(d), 64'(32'h1000_0000 + i));
    end

    holdReq(12'h100, 8, cyc, d);
    checkOutput("redirLatency", 64'(cyc), 64'd4);
    checkOutput("redirData", 64'(d), 64'h1000_0040);
    holdReq(12'h104, 8, cyc, d);
    checkOutput("afterRedir", 64'(cyc), 64'd1);

    holdReq(12'h102, 8, cyc, d);
    checkOutput("lowBitsLatency", 64'(cyc), 64'd4);
    checkOutput("lowBitsData", 64'(d), 64'h1000_0040);

    holdReq(12'hFFC, 8, cyc, d);
    checkOutput("wrapLastData", 64'(d), 64'h1000_03FF);
    holdReq(12'h000, 8, cyc, d);
    checkOutput("wrapLatency", 64'(cyc), 64'd1);
    checkOutput("wrapData", 64'(d), 64'h1000_0000);

    holdReq(12'h200, 8, cyc, d);
    pulseReset(2);
    holdReq(RST_ADDR, 8, cyc, d);
    checkOutput("postRstLatency", 64'(cyc), 64'd2);
    checkOutput("postRstData", 64'(d), 64'(32'h1000_0000 + 32'(RST_ADDR[MAW-1:2])));

    active = 1'b0;
    cur = '0;
    last = '0;
    for (int i = 0; i < 500; i++) begin
      if (!active) begin
        if ($urandom_range(0, 5) == 0) begin
          applyStimulus(1'b0, 12'($urandom), a);
          continue;
        end
        active = 1'b1;
        r = $urandom_range(0, 9);
        cur = (r < 7) ? last + 12'd4 : 12'($urandom);
      end
      applyStimulus(1'b1, cur, a);
      if (a) begin
        active = 1'b0;
        last = {cur[MAW-1:2], 2'b00};
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
